// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART transmitter types and parity-mode constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// uart_tx_if : request/serial-status bundle between a controller and uart_tx
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             i_dv;
    logic [WIDTH-1:0] i_data;
    logic             o_tx;
    logic             o_busy;
    logic             o_done;

    modport master (output i_dv, output i_data, input o_tx, input o_busy, input o_done);
    modport slave  (input i_dv, input i_data, output o_tx, output o_busy, output o_done);
endinterface

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// uart_baud_counter : bit-period timer, reloaded at each bit start and
// producing a one-cycle tick in the last cycle of the period
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic load,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            cnt     <= CNT_W'(CLKS_PER_BIT - 1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign tick = running && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : serial transmitter, start / WIDTH data (LSB first) / optional
// parity / 1-2 stop bits, with registered line and status outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     i_reset_n,
    uart_tx_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH + 1);

    generate
        if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
            PARITY < 0 || PARITY > 2) begin : g_bad_params
            $error("uart_tx: illegal CLKS_PER_BIT, STOP_BITS or PARITY value");
        end
    endgenerate

    tx_state_t        state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             par_bit, par_bit_nxt;
    logic             tx, tx_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;
    logic             load;
    logic             tick;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .load     (load),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            idx     <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            idx     <= idx_nxt;
            par_bit <= par_bit_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Every output is computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        idx_nxt     = idx;
        par_bit_nxt = par_bit;
        tx_nxt      = tx;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        load        = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (bus.i_dv) begin
                    shreg_nxt   = bus.i_data;
                    par_bit_nxt = (^bus.i_data) ^ (PARITY == PAR_ODD);
                    idx_nxt     = '0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    load        = 1'b1;
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                    idx_nxt   = '0;
                    load      = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    load = 1'b1;
                    if (idx == IDX_W'(WIDTH - 1)) begin
                        idx_nxt = '0;
                        if (PARITY != PAR_NONE) begin
                            tx_nxt    = par_bit;
                            state_nxt = ST_PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        tx_nxt    = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_nxt    = 1'b1;
                    idx_nxt   = '0;
                    load      = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                        load    = 1'b1;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_tx   = tx;
    assign bus.o_busy = busy;
    assign bus.o_done = done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// tb_uart_tx : four differently-configured transmitters driven with directed
// and random frames, line waveform compared against a bit-list model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;
    import uart_pkg::*;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic       dv  [NDUT];
    logic [7:0] din [NDUT];
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.WIDTH(8)) bus0 ();
    uart_tx_if #(.WIDTH(8)) bus1 ();
    uart_tx_if #(.WIDTH(8)) bus2 ();
    uart_tx_if #(.WIDTH(8)) bus3 ();

    assign bus0.i_dv = dv[0];  assign bus0.i_data = din[0];
    assign bus1.i_dv = dv[1];  assign bus1.i_data = din[1];
    assign bus2.i_dv = dv[2];  assign bus2.i_data = din[2];
    assign bus3.i_dv = dv[3];  assign bus3.i_data = din[3];

    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(PAR_NONE), .STOP_BITS(1))
        dut0 (.clk(clk), .i_reset_n(rst_n), .bus(bus0));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(PAR_EVEN), .STOP_BITS(1))
        dut1 (.clk(clk), .i_reset_n(rst_n), .bus(bus1));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(PAR_ODD), .STOP_BITS(1))
        dut2 (.clk(clk), .i_reset_n(rst_n), .bus(bus2));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(2), .PARITY(PAR_NONE), .STOP_BITS(2))
        dut3 (.clk(clk), .i_reset_n(rst_n), .bus(bus3));

    function automatic int cfg_cpb(int i);
        return (i == 3) ? 2 : 4;
    endfunction

    function automatic int cfg_par(int i);
        case (i)
            1:       return PAR_EVEN;
            2:       return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic int cfg_stop(int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic logic get_tx(int i);
        case (i)
            0: return bus0.o_tx;  1: return bus1.o_tx;
            2: return bus2.o_tx;  default: return bus3.o_tx;
        endcase
    endfunction

    function automatic logic get_busy(int i);
        case (i)
            0: return bus0.o_busy;  1: return bus1.o_busy;
            2: return bus2.o_busy;  default: return bus3.o_busy;
        endcase
    endfunction

    function automatic logic get_done(int i);
        case (i)
            0: return bus0.o_done;  1: return bus1.o_done;
            2: return bus2.o_done;  default: return bus3.o_done;
        endcase
    endfunction

    // Reference: list the frame's bits, then stretch each over one bit period.
    function automatic logic [63:0] expect_wave(int i, logic [7:0] d, output int len);
        bit          q[$];
        logic [63:0] w = '0;
        int          c = cfg_cpb(i);
        q.push_back(1'b0);
        for (int b = 0; b < 8; b++) q.push_back(d[b]);
        if (cfg_par(i) == PAR_EVEN) q.push_back(^d);
        if (cfg_par(i) == PAR_ODD)  q.push_back(~^d);
        for (int s = 0; s < cfg_stop(i); s++) q.push_back(1'b1);
        len = q.size() * c;
        for (int k = 0; k < len; k++) w[k] = q[k / c];
        return w;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns on the falling edge where o_done is seen.
    task automatic run_frame(int i, logic [7:0] d, int hold, int mid_at, bit tail);
        int          exp_len, busy_cnt, pre_low, done_in, cyc, restart;
        logic [63:0] exp_w, got_w;
        bit          seen, fin;
        logic        done_end, tx_end;
        exp_w    = expect_wave(i, d, exp_len);
        got_w    = '0;
        busy_cnt = 0; pre_low = 0; done_in = 0; cyc = 0; restart = 0;
        seen = 0; fin = 0; done_end = 0; tx_end = 0;
        dv[i]  = 1'b1;
        din[i] = d;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) din[i] = 8'($urandom);
            if (cyc == hold) dv[i] = 1'b0;
            if (mid_at != 0 && cyc == mid_at) dv[i] = 1'b1;
            if (mid_at != 0 && cyc == mid_at + 3) dv[i] = 1'b0;
            if (get_busy(i)) begin
                if (busy_cnt < 64) got_w[busy_cnt] = get_tx(i);
                busy_cnt++;
                seen = 1;
                if (get_done(i)) done_in++;
            end else if (!seen) begin
                pre_low++;
            end else begin
                fin      = 1;
                done_end = get_done(i);
                tx_end   = get_tx(i);
            end
        end
        dv[i] = 1'b0;
        check("frame_end_seen", 64'(fin), 64'd1);
        check("busy_rise_delay", 64'(pre_low), 64'd0);
        check("busy_len", 64'(busy_cnt), 64'(exp_len));
        check("tx_wave", got_w, exp_w);
        check("done_during_busy", 64'(done_in), 64'd0);
        check("done_at_end", 64'(done_end), 64'd1);
        check("tx_after_frame", 64'(tx_end), 64'd1);
        if (tail) begin
            @(negedge clk);
            check("done_cleared", 64'(get_done(i)), 64'd0);
            for (int k = 0; k < 4; k++) begin
                if (get_busy(i)) restart++;
                @(negedge clk);
            end
            check("no_second_frame", 64'(restart), 64'd0);
        end
    endtask

    task automatic reset_mid(int i, logic [7:0] d);
        int c = cfg_cpb(i);
        dv[i]  = 1'b1;
        din[i] = d;
        @(negedge clk);
        dv[i] = 1'b0;
        repeat (4 * c) @(negedge clk);
        check("bit3_before_reset", 64'(get_tx(i)), 64'(d[3]));
        rst_n = 1'b0;
        #1;
        check("reset_async_tx", 64'(get_tx(i)), 64'd1);
        check("reset_async_busy", 64'(get_busy(i)), 64'd0);
        check("reset_async_done", 64'(get_done(i)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {62'd0, get_busy(i), get_tx(i)}, 64'd1);
        run_frame(i, 8'h3C, 1, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            dv[i]  = 1'b0;
            din[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            check("reset_state", {61'd0, get_done(i), get_busy(i), get_tx(i)}, 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(0, 8'hA5, 1, 0, 1);
        run_frame(1, 8'h07, 1, 0, 1);
        run_frame(2, 8'h07, 1, 0, 1);
        run_frame(0, 8'($urandom), 2, 12, 1);
        run_frame(0, 8'h55, 1, 0, 0);
        run_frame(0, 8'h0F, 1, 0, 1);
        reset_mid(0, 8'($urandom));
        run_frame(3, 8'hFF, 1, 0, 1);

        for (int r = 0; r < 24; r++) begin
            int i;
            i = int'($urandom_range(0, NDUT - 1));
            run_frame(i, 8'($urandom), int'($urandom_range(1, 3)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 15)) : 0,
                      (r == 23) || ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
